usb_data_rx: RTL
================

# usb_data_rx

Receive-side DATA-packet stage between the USB packet byte decoder and `setup_buffer`. It accepts a byte stream framed by start and end strobes and checks the PID of DATA0 and DATA1 packets. It strips the PID and the two trailing CRC16 bytes and forwards only payload bytes on `data_byte`/`data_valid`, which drive `setup_buffer`'s `byte_in`/`byte_valid`. At end of packet it reports CRC, length and error status, so the control-endpoint logic can accept or discard what was buffered.

## Interface
- `MAX_LEN`, 64: maximum payload bytes forwarded per packet.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_byte`  in  8  byte from the packet decoder; byte 0 is the PID.
- `rx_valid`  in  1  `rx_byte` is valid this cycle; back-to-back bytes are allowed.
- `rx_sop`  in  1  qualifies `rx_valid`: this byte is the first byte (the PID) of a packet.
- `rx_eop`  in  1  single-cycle pulse, end of packet; may coincide with the last `rx_valid`.
- `rx_error`  in  1  single-cycle pulse for a line, bit-stuff or framing error in the current packet.
- `data_byte`  out  8  payload byte.
- `data_valid`  out  1  single-cycle pulse; `data_byte` is valid.
- `pkt_start`  out  1  single-cycle pulse; a DATA0 or DATA1 PID was accepted.
- `pkt_data1`  out  1  PID of the current or last accepted packet was DATA1.
- `pkt_done`  out  1  single-cycle pulse; the accepted packet has ended.
- `pkt_ok`  out  1  valid with `pkt_done`. Set only when the CRC residue is good, there was no error, no overflow, and at least 2 bytes followed the PID.
- `pkt_len`  out  `$clog2(MAX_LEN+1)`  payload bytes forwarded; valid with `pkt_done`.

## Operation
- **States:**
  - `IDLE`: waits for `rx_valid && rx_sop`.
  - `PAYLOAD`: receiving the data bytes of an accepted packet.
  - `SKIP`: ignores input until `rx_eop`.
- **PID check (`IDLE`):**
  - The PID is valid when `rx_byte[7:4] == ~rx_byte[3:0]`.
  - 0xC3 (DATA0) or 0x4B (DATA1): go to `PAYLOAD`, pulse `pkt_start`, load `pkt_data1`, initialise the CRC to 0xFFFF and clear the counters.
  - Any other PID, including DATA2 and MDATA: go to `SKIP` with no outputs.
  - `rx_valid` without `rx_sop` in `IDLE` is ignored.
- **Two-byte hold pipeline:**
  - Post-PID bytes enter a 2-entry shift register (h0 newest, h1 oldest) plus a fill count of 0..2.
  - On a new byte with fill == 2, h1 is forwarded as a payload byte. Forwarding stops once `pkt_len` reaches `MAX_LEN`.
  - The two bytes held at `rx_eop` are the CRC and are never forwarded.
- **CRC16:**
  - Every post-PID byte, CRC bytes included, is folded in LSB-first.
  - Right-shift implementation, polynomial 0xA001, init 0xFFFF.
  - The CRC is good when the register equals the residue 0xB001 after the last byte.
- **Overflow:** a forward attempt when `pkt_len == MAX_LEN` sets the overflow flag. The byte is dropped and `pkt_len` saturates.
- **`rx_error`:** in `PAYLOAD`, sets the error flag and moves to `SKIP`-equivalent handling. No further forwarding; `pkt_done` still fires at `rx_eop` with `pkt_ok = 0`.
- **Short packet:** `rx_eop` with fill < 2 gives `pkt_done` with `pkt_ok = 0`.
- **Simultaneous events:**
  - `rx_valid` with `rx_eop` in the same cycle: the byte is processed first, then end of packet.
  - `rx_valid && rx_sop` while in `PAYLOAD` aborts the current packet: `pkt_done` with `pkt_ok = 0` that cycle, and the new PID is evaluated as in `IDLE`.
  - `rx_sop` in `SKIP` is evaluated as in `IDLE`.
- **End of packet:** after `rx_eop`, always return to `IDLE`.

## Timing
- **Reset:** asserting `reset` immediately clears every output, the holding registers, the counters and the flags, and sets the state to `IDLE`, even mid-packet. There is no `pkt_done` for an aborted packet.
- **Registered outputs:** all outputs come from flops.
- **Forwarding latency:** the `rx_valid` of byte k+2 (counting from the first byte after the PID) produces `data_valid` for byte k on the next cycle.
- **PID latency:** `rx_valid` of the PID produces `pkt_start` on the next cycle.
- **End-of-packet latency:** `rx_eop` in cycle t produces `pkt_done`, `pkt_ok` and `pkt_len` in cycle t+1. No `data_valid` is issued in cycle t+1 for CRC bytes.
- **Output holds:**
  - `pkt_len` and `pkt_ok` hold until the next `pkt_start`.
  - `data_byte` holds its last value between pulses.
- **Throughput:** one byte per cycle sustained; there is no backpressure.

## Structure
- **Shared package** (`types.sv`):
  - `PidType` enum: DATA0 = 0xC3, DATA1 = 0x4B, DATA2 = 0x87, MDATA = 0x0F.
  - `CRC16_POLY_REFL` = 16'hA001.
  - `CRC16_INIT` = 16'hFFFF.
  - `CRC16_RESIDUE` = 16'hB001.
- **Sub-module:** one, `crc16_byte`. It is combinational: 16-bit current CRC plus 8-bit data in, next CRC out (8 unrolled LSB-first steps). It is reusable by the TX path.
- **Top level:** the state machine, hold pipeline, counters and flags live in `usb_data_rx`.

## Test plan
- **Good SETUP data:** send C3 80 06 00 01 00 00 40 00 DD 94, then `rx_eop`. Expect `pkt_start`, 8 `data_valid` pulses carrying 80 06 00 01 00 00 40 00, then `pkt_done` with `pkt_ok = 1`, `pkt_len = 8`, `pkt_data1 = 0`.
- **Zero-length DATA1:** send 4B 00 00, then `rx_eop`. Expect no `data_valid`, then `pkt_done` with `pkt_ok = 1`, `pkt_len = 0`, `pkt_data1 = 1`.
- **Corrupt CRC:** send the first packet with the last byte 0x95. Expect the same 8 payload bytes, then `pkt_ok = 0`.
- **Rejected PIDs:** send 0x87 and 0x69 packets, and a PID 0xC2 with a bad complement. Expect no outputs at all.
- **Overflow:** with `MAX_LEN = 4`, send an 8-byte payload with valid CRC. Expect 4 pulses, `pkt_len = 4`, `pkt_ok = 0`.
- **Aborts:**
  - Pulse `rx_error` after byte 3: forwarding stops and `pkt_ok = 0` at `rx_eop`.
  - `rx_sop` mid-packet: the old packet ends with `pkt_ok = 0` and the new packet is decoded correctly.
  - Async `reset` mid-packet: all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/usb_data_rx_pkg.sv
// Shared types and constants for the USB DATA-packet receive path.
package usb_data_rx_pkg;

    typedef enum logic [7:0] {
        PID_DATA0 = 8'hC3,
        PID_DATA1 = 8'h4B,
        PID_DATA2 = 8'h87,
        PID_MDATA = 8'h0F
    } pid_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_SKIP
    } rx_state_e;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

    // A PID byte carries its own complement in the upper nibble.
    function automatic logic pid_check(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/crc16_byte.sv
// One-byte CRC16 update, LSB-first, reflected polynomial; shared with the TX path.
module crc16_byte
    import usb_data_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_next_c
);

    // Eight unrolled right-shift steps.
    always_comb begin
        crc_next_c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_next_c = crc_next_c[0] ? ((crc_next_c >> 1) ^ CRC16_POLY_REFL)
                                       : (crc_next_c >> 1);
        end
    end

endmodule

// File: rtl/usb_data_rx.sv
// DATA0/DATA1 receive stage: PID check, payload forwarding, CRC/length status.
module usb_data_rx
    import usb_data_rx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_valid,
    input  logic                         rx_sop,
    input  logic                         rx_eop,
    input  logic                         rx_error,
    output logic [7:0]                   data_byte,
    output logic                         data_valid,
    output logic                         pkt_start,
    output logic                         pkt_data1,
    output logic                         pkt_done,
    output logic                         pkt_ok,
    output logic [$clog2(MAX_LEN+1)-1:0] pkt_len
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    rx_state_e          state;
    logic [15:0]        crc;
    logic [15:0]        crc_byte_c;
    logic [7:0]         h0;
    logic [7:0]         h1;
    logic [1:0]         fill;
    logic [LEN_W-1:0]   len;
    logic               ovf;
    logic               err;

    logic               start_c;
    logic               pid_ok_c;
    logic               take_c;
    logic               fwd_try_c;
    logic               fwd_c;
    logic [15:0]        crc_upd_c;
    logic [1:0]         fill_upd_c;
    logic [LEN_W-1:0]   len_upd_c;
    logic               ovf_upd_c;
    logic               err_upd_c;

    crc16_byte u_crc (
        .crc_in     (crc),
        .data       (rx_byte),
        .crc_next_c (crc_byte_c)
    );

    // Datapath view of the current cycle's byte, applied before any end of packet.
    always_comb begin
        start_c    = rx_valid && rx_sop;
        pid_ok_c   = start_c && pid_check(rx_byte) &&
                     ((rx_byte == PID_DATA0) || (rx_byte == PID_DATA1));
        take_c     = (state == ST_PAYLOAD) && rx_valid && !rx_sop && !err && !rx_error;
        fwd_try_c  = take_c && (fill == 2'd2);
        fwd_c      = fwd_try_c && (len != LEN_W'(MAX_LEN));
        crc_upd_c  = take_c ? crc_byte_c : crc;
        fill_upd_c = (take_c && (fill != 2'd2)) ? fill + 2'd1 : fill;
        len_upd_c  = len + LEN_W'(fwd_c);
        ovf_upd_c  = ovf || (fwd_try_c && (len == LEN_W'(MAX_LEN)));
        err_upd_c  = err || rx_error;
    end

    // Packet state machine with hold pipeline, counters, flags and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            crc        <= 16'h0000;
            h0         <= 8'h00;
            h1         <= 8'h00;
            fill       <= 2'd0;
            len        <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            data_byte  <= 8'h00;
            data_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_data1  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            pkt_len    <= '0;
        end else begin
            data_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;

            case (state)
                ST_PAYLOAD: begin
                    crc  <= crc_upd_c;
                    fill <= fill_upd_c;
                    len  <= len_upd_c;
                    ovf  <= ovf_upd_c;
                    err  <= err_upd_c;
                    if (take_c) begin
                        h0 <= rx_byte;
                        h1 <= h0;
                    end
                    if (fwd_c) begin
                        data_byte  <= h1;
                        data_valid <= 1'b1;
                    end
                    if (start_c) begin
                        // New PID mid-packet aborts the current one.
                        pkt_done <= 1'b1;
                        pkt_ok   <= 1'b0;
                        pkt_len  <= len;
                    end else if (rx_eop) begin
                        pkt_done <= 1'b1;
                        pkt_ok   <= (crc_upd_c == CRC16_RESIDUE) && !err_upd_c &&
                                    !ovf_upd_c && (fill_upd_c == 2'd2);
                        pkt_len  <= len_upd_c;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    if (rx_eop) begin
                        state <= ST_IDLE;
                    end
                end
            endcase

            // PID evaluation is identical from every state.
            if (start_c) begin
                if (pid_ok_c) begin
                    state     <= ST_PAYLOAD;
                    pkt_start <= 1'b1;
                    pkt_data1 <= (rx_byte == PID_DATA1);
                    crc       <= CRC16_INIT;
                    fill      <= 2'd0;
                    len       <= '0;
                    ovf       <= 1'b0;
                    err       <= 1'b0;
                    if (rx_eop) begin
                        pkt_done <= 1'b1;
                        pkt_ok   <= 1'b0;
                        pkt_len  <= '0;
                    end
                end else begin
                    state <= ST_SKIP;
                end
                if (rx_eop) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule
